// File: rtl/dmem_stream_initiator_if.sv
// dmem_stream_initiator_if
//  Groups the control, byte-stream and memory-bus signals of the data-memory
//  stream initiator.
//  master : the initiator itself (drives s_ready, m_byte, m_valid, mem_addr,
//           write_data, mem_write, busy, done)
//  slave  : the environment (drives start, dir, base_addr, word_count,
//           s_byte, s_valid, m_ready, read_data)
interface dmem_stream_initiator_if;
  logic        start;
  logic        dir;
  logic [31:0] base_addr;
  logic [7:0]  word_count;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_byte;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic        busy;
  logic        done;

  modport master (
    input  start, dir, base_addr, word_count, s_byte, s_valid, m_ready, read_data,
    output s_ready, m_byte, m_valid, mem_addr, write_data, mem_write, busy, done
  );

  modport slave (
    output start, dir, base_addr, word_count, s_byte, s_valid, m_ready, read_data,
    input  s_ready, m_byte, m_valid, mem_addr, write_data, mem_write, busy, done
  );
endinterface

// File: rtl/dmem_stream_initiator.sv
// dmem_stream_initiator
//  Moves byte streams between the I2C side and the 32-bit byte-addressed data
//  memory. Write mode packs inbound bytes little-endian into words and writes
//  them; read mode fetches words and emits them LSB first.
// Ports
//  clk    : system clock, all state on the rising edge
//  reset  : synchronous active-high reset
//  bus    : dmem_stream_initiator_if.master (control, byte streams, memory bus)
// Parameters
//  MEM_BYTES : memory size in bytes (power of 2); word address wraps modulo it
module dmem_stream_initiator #(
  parameter int MEM_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  dmem_stream_initiator_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WRITE = 3'd2,
    FETCH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] word_r;
  logic [31:0] shift_r;
  logic [7:0]  remaining_r;
  logic [1:0]  beat_r;
  logic        s_ready_r;
  logic        m_valid_r;
  logic        mem_write_r;
  logic        busy_r;
  logic        done_r;

  // Next word address, wrapping at the top of memory.
  function automatic logic [31:0] next_word_addr(input logic [31:0] a);
    return (a + 32'd4) & ADDR_MASK;
  endfunction

  // Outputs are straight register taps; every one is computed in the FSM.
  assign bus.s_ready    = s_ready_r;
  assign bus.m_valid    = m_valid_r;
  assign bus.m_byte     = shift_r[7:0];
  assign bus.mem_addr   = addr_r;
  assign bus.write_data = word_r;
  assign bus.mem_write  = mem_write_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

  // Transfer FSM with registered outputs set on entry to each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= 32'd0;
      word_r      <= 32'd0;
      shift_r     <= 32'd0;
      remaining_r <= 8'd0;
      beat_r      <= 2'd0;
      s_ready_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      mem_write_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      // Single-cycle strobes fall unless a transition below re-raises them.
      mem_write_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            addr_r      <= bus.base_addr & ~32'd3;
            remaining_r <= bus.word_count;
            beat_r      <= 2'd0;
            busy_r      <= 1'b1;
            if (bus.word_count == 8'd0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else if (!bus.dir) begin
              state_r   <= FILL;
              s_ready_r <= 1'b1;
            end else begin
              state_r <= FETCH;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        FILL: begin
          if (bus.s_valid && s_ready_r) begin
            // Shifting in from the top leaves byte 0 in bits [7:0] after four.
            word_r <= {bus.s_byte, word_r[31:8]};
            beat_r <= beat_r + 2'd1;
            if (beat_r == 2'd3) begin
              s_ready_r   <= 1'b0;
              mem_write_r <= 1'b1;
              state_r     <= WRITE;
            end else begin
              state_r <= FILL;
            end
          end else begin
            state_r <= FILL;
          end
        end
        WRITE: begin
          addr_r      <= next_word_addr(addr_r);
          remaining_r <= remaining_r - 8'd1;
          if (remaining_r == 8'd1) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r   <= FILL;
            s_ready_r <= 1'b1;
          end
        end
        FETCH: begin
          shift_r   <= bus.read_data;
          beat_r    <= 2'd0;
          m_valid_r <= 1'b1;
          state_r   <= DRAIN;
        end
        DRAIN: begin
          if (bus.m_ready && m_valid_r) begin
            shift_r <= {8'd0, shift_r[31:8]};
            beat_r  <= beat_r + 2'd1;
            if (beat_r == 2'd3) begin
              m_valid_r   <= 1'b0;
              addr_r      <= next_word_addr(addr_r);
              remaining_r <= remaining_r - 8'd1;
              if (remaining_r == 8'd1) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= FETCH;
              end
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stream_initiator.sv
// tb_dmem_stream_initiator
//  Drives table-driven and random transfers into dmem_stream_initiator with a
//  64-byte behavioural memory attached, and compares writes, read bytes,
//  done timing and mode exclusivity against a transfer-level reference model.
module tb_dmem_stream_initiator;
  localparam int MEM_BYTES = 64;

  typedef struct {
    logic        dir;
    logic [31:0] base;
    logic [7:0]  cnt;
    int          stall;      // 0 none, 1 random, 2 m_ready low cycles 3..5
    logic [7:0]  seed;       // 0 random bytes, else bytes seed, seed+1, ...
    int          exp_done;   // cycle of done after start, -1 = unchecked
    logic [31:0] exp_addr;   // word address presented after start
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic [5:0] ra;

  always #5 clk = ~clk;

  dmem_stream_initiator_if bus();

  dmem_stream_initiator #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign ra            = bus.mem_addr[5:0];
  assign bus.read_data = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[ra]         <= bus.write_data[7:0];
      mem[ra + 6'd1]  <= bus.write_data[15:8];
      mem[ra + 6'd2]  <= bus.write_data[23:16];
      mem[ra + 6'd3]  <= bus.write_data[31:24];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_transfer(input vec_t v);
    logic [31:0] addr;
    logic [7:0]  tx[$];
    logic [7:0]  exp_rd[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [7:0]  b;
    logic [31:0] word;
    logic        sv;
    logic        mr;
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          viol;

    // Reference model: compute every write and every read byte up front.
    addr = v.base & ~32'd3;
    for (int w = 0; w < int'(v.cnt); w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (v.dir == 1'b0) begin
          b = (v.seed != 8'd0) ? 8'(int'(v.seed) + 4 * w + k) : 8'($urandom_range(0, 255));
          tx.push_back(b);
          word = word | (32'(b) << (8 * k));
          ref_mem[(int'(addr % MEM_BYTES) + k) % MEM_BYTES] = b;
        end else begin
          exp_rd.push_back(ref_mem[(int'(addr % MEM_BYTES) + k) % MEM_BYTES]);
        end
      end
      if (v.dir == 1'b0) begin
        exp_wa.push_back(addr);
        exp_wd.push_back(word);
      end
      addr = (addr + 32'd4) % MEM_BYTES;
    end

    @(negedge clk);
    bus.start      = 1'b1;
    bus.dir        = v.dir;
    bus.base_addr  = v.base;
    bus.word_count = v.cnt;
    bus.s_valid    = 1'b0;
    bus.m_ready    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc      = 1;
    done_cnt = 0;
    done_cyc = -1;
    viol     = 0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("addr_after_start", bus.mem_addr, v.exp_addr);

    while (done_cnt == 0 && cyc < 2000) begin
      case (v.stall)
        0: begin sv = 1'b1; mr = 1'b1; end
        2: begin sv = 1'b1; mr = !(cyc >= 3 && cyc <= 5); end
        default: begin sv = ($urandom_range(0, 3) != 0); mr = ($urandom_range(0, 3) != 0); end
      endcase
      bus.s_valid = sv && (tx.size() > 0);
      bus.s_byte  = (tx.size() > 0) ? tx[0] : 8'h00;
      bus.m_ready = mr;

      if ((v.dir && (bus.s_ready || bus.mem_write)) || (!v.dir && bus.m_valid)) viol++;
      if (bus.mem_write) begin
        if (exp_wa.size() == 0) viol++;
        else begin
          check("write_addr", bus.mem_addr, exp_wa[0]);
          check("write_data", bus.write_data, exp_wd[0]);
          void'(exp_wa.pop_front());
          void'(exp_wd.pop_front());
        end
      end
      if (bus.m_valid) begin
        if (exp_rd.size() == 0) viol++;
        else begin
          check("read_byte", 32'(bus.m_byte), 32'(exp_rd[0]));
          if (bus.m_ready) void'(exp_rd.pop_front());
        end
      end
      if (bus.s_ready && bus.s_valid) void'(tx.pop_front());
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end

    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    check("done_once", 32'(done_cnt), 32'd1);
    check("busy_falls", 32'(bus.busy), 32'd0);
    check("done_clears", 32'(bus.done), 32'd0);
    check("mode_exclusive", 32'(viol), 32'd0);
    check("writes_left", 32'(exp_wa.size()), 32'd0);
    check("reads_left", 32'(exp_rd.size()), 32'd0);
    check("bytes_left", 32'(tx.size()), 32'd0);
    if (v.exp_done >= 0) check("done_latency", 32'(done_cyc), 32'(v.exp_done));
  endtask

  vec_t vecs[8];
  vec_t rv;
  int   cnt_bad;

  initial begin
    vecs[0] = '{1'b0, 32'd8,    8'd2, 0, 8'h11, 11, 32'd8};
    vecs[1] = '{1'b1, 32'd4,    8'd1, 0, 8'h00, 6,  32'd4};
    vecs[2] = '{1'b0, 32'd60,   8'd2, 0, 8'h00, 11, 32'd60};
    vecs[3] = '{1'b1, 32'h20,   8'd2, 2, 8'h00, 14, 32'h20};
    vecs[4] = '{1'b0, 32'd0,    8'd0, 0, 8'h00, 1,  32'd0};
    vecs[5] = '{1'b1, 32'h3D,   8'd3, 1, 8'h00, -1, 32'h3C};
    vecs[6] = '{1'b0, 32'h13,   8'd4, 1, 8'h00, -1, 32'h10};
    vecs[7] = '{1'b1, 32'h0E,   8'd2, 0, 8'h00, 11, 32'h0C};

    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    bus.start      = 1'b0;
    bus.dir        = 1'b0;
    bus.base_addr  = 32'd0;
    bus.word_count = 8'd0;
    bus.s_byte     = 8'd0;
    bus.s_valid    = 1'b0;
    bus.m_ready    = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_addr", bus.mem_addr, 32'd0);
    check("reset_outs", {26'd0, bus.s_ready, bus.m_valid, bus.mem_write, bus.done, 2'd0}, 32'd0);
    check("reset_mbyte", 32'(bus.m_byte), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_transfer(vecs[i]);

    // Reset two bytes into a write: transfer is abandoned silently.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dir        = 1'b0;
    bus.base_addr  = 32'h0B;
    bus.word_count = 8'd2;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_byte  = 8'hAA;
    @(negedge clk);
    bus.s_byte = 8'hBB;
    @(negedge clk);
    bus.s_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_addr", bus.mem_addr, 32'd0);
    cnt_bad     = 0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_write || bus.s_ready || bus.done || bus.busy) cnt_bad++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    check("abort_quiet", 32'(cnt_bad), 32'd0);
    rv = '{1'b0, 32'h0B, 8'd1, 0, 8'h00, 6, 32'd8};
    run_transfer(rv);

    // Random transfers, any direction, base and count, random back-pressure.
    for (int i = 0; i < 20; i++) begin
      rv.dir      = 1'($urandom_range(0, 1));
      rv.base     = $urandom;
      rv.cnt      = 8'($urandom_range(0, 4));
      rv.stall    = 1;
      rv.seed     = 8'h00;
      rv.exp_done = -1;
      rv.exp_addr = rv.base & ~32'd3;
      run_transfer(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
